// File: rtl/sw_step_ctrl_if.sv
// Switch/step controller bus: raw operator inputs in, debounced levels and LFSR requests out.
interface sw_step_ctrl_if;
    logic [9:0] sw_in;
    logic       btn_auto;
    logic [9:0] sw_clean;
    logic [7:0] seed;
    logic       step_pulse;
    logic       load_pulse;
    logic       auto_mode;

    modport master (
        output sw_in, btn_auto,
        input  sw_clean, seed, step_pulse, load_pulse, auto_mode
    );

    modport slave (
        input  sw_in, btn_auto,
        output sw_clean, seed, step_pulse, load_pulse, auto_mode
    );
endinterface

// File: rtl/sw_step_ctrl.sv
// Debounces operator switches and turns them into step/load requests for a downstream LFSR.
// Define SW_STEP_AUTO_STEP_EN to build the AUTO state (btn_auto toggle + prescaled stepping).
module sw_step_ctrl #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned AUTO_DIV  = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    sw_step_ctrl_if.slave bus
);

`ifdef SW_STEP_AUTO_STEP_EN
    localparam int NB = 11;  // bit 10 carries btn_auto through the same filter
`else
    localparam int NB = 10;
`endif
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    logic [NB-1:0]         raw;
    logic [NB-1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NB-1:0]         clean_q, clean_d;
    logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
    logic                  step_prev_q, step_prev_d;
    logic                  step_edge, load_req, man_step;
    logic [7:0]            seed_q;
    logic                  step_pulse_q, load_pulse_q, auto_mode_q;

`ifdef SW_STEP_AUTO_STEP_EN
    logic btn_prev_q, btn_prev_d;
    assign raw = {bus.btn_auto, bus.sw_in};
`else
    logic unused_btn;
    assign unused_btn = bus.btn_auto;
    assign raw        = bus.sw_in;
`endif

    // The counter holds DB_CYCLES-1 differing samples; the next differing one flips the level.
    always_comb begin
        sync1_d     = raw;
        sync2_d     = sync1_q;
        clean_d     = clean_q;
        cnt_d       = cnt_q;
        step_prev_d = clean_q[8];
`ifdef SW_STEP_AUTO_STEP_EN
        btn_prev_d  = clean_q[10];
`endif
        for (int i = 0; i < NB; i++) begin
            if (sync2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                clean_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            clean_q     <= '0;
            cnt_q       <= '0;
            step_prev_q <= 1'b0;
`ifdef SW_STEP_AUTO_STEP_EN
            btn_prev_q  <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            clean_q     <= clean_d;
            cnt_q       <= cnt_d;
            step_prev_q <= step_prev_d;
`ifdef SW_STEP_AUTO_STEP_EN
            btn_prev_q  <= btn_prev_d;
`endif
        end
    end

    assign step_edge = clean_q[8] & ~step_prev_q;
    assign load_req  = step_edge & clean_q[9];
    assign man_step  = step_edge & ~clean_q[9];

`ifdef SW_STEP_AUTO_STEP_EN
    localparam int PW = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic          btn_edge, wrap;

    assign btn_edge = clean_q[10] & ~btn_prev_q;
    assign wrap     = (state_q == AUTO) && (presc_q == PW'(AUTO_DIV - 1));

    // Load wins over a coincident wrap and restarts the step period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MANUAL;
            presc_q      <= '0;
            seed_q       <= '0;
            step_pulse_q <= 1'b0;
            load_pulse_q <= 1'b0;
            auto_mode_q  <= 1'b0;
        end else begin
            load_pulse_q <= load_req;
            if (load_req) seed_q <= clean_q[7:0];
            case (state_q)
                MANUAL: begin
                    step_pulse_q <= man_step;
                    presc_q      <= '0;
                    if (btn_edge) begin
                        state_q     <= AUTO;
                        auto_mode_q <= 1'b1;
                    end
                end
                AUTO: begin
                    step_pulse_q <= wrap & ~load_req;
                    if (btn_edge) begin
                        state_q     <= MANUAL;
                        auto_mode_q <= 1'b0;
                        presc_q     <= '0;
                    end else if (load_req || wrap) begin
                        presc_q <= '0;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q       <= '0;
            step_pulse_q <= 1'b0;
            load_pulse_q <= 1'b0;
        end else begin
            step_pulse_q <= man_step;
            load_pulse_q <= load_req;
            if (load_req) seed_q <= clean_q[7:0];
        end
    end
    assign auto_mode_q = 1'b0;
`endif

    assign bus.sw_clean   = clean_q[9:0];
    assign bus.seed       = seed_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.load_pulse = load_pulse_q;
    assign bus.auto_mode  = auto_mode_q;

endmodule

// File: tb/tb_sw_step_ctrl.sv
// Bench for sw_step_ctrl: directed scenarios plus random switch activity against a sample-window model.
module tb_sw_step_ctrl;
    localparam int DB = 4;
    localparam int AD = 8;
`ifdef SW_STEP_AUTO_STEP_EN
    localparam bit HAS_AUTO = 1'b1;
`else
    localparam bit HAS_AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    sw_step_ctrl_if bus();

    sw_step_ctrl #(.DB_CYCLES(DB), .AUTO_DIV(AD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int steps = 0, loads = 0, first_step = -1;

    // Reference: a level is accepted once DB consecutive raw samples (seen two
    // synchronizer cycles late) agree and differ from the current level.
    logic [10:0] hist [DB+2];
    logic [10:0] m_clean = '0, m_prev = '0;
    logic [7:0]  m_seed = '0;
    logic        m_step = 1'b0, m_load = 1'b0, m_auto = 1'b0;
    int          m_next = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [10:0] raw;
        logic rise8, riseb, fire, same;
        raw = {1'b0, bus.sw_in};
        if (HAS_AUTO) raw[10] = bus.btn_auto;
        if (rst) begin
            for (int k = 0; k < DB + 2; k++) hist[k] = '0;
            m_clean = '0; m_prev = '0; m_seed = '0;
            m_step = 1'b0; m_load = 1'b0; m_auto = 1'b0;
        end else begin
            rise8  = m_clean[8] & ~m_prev[8];
            riseb  = m_clean[10] & ~m_prev[10];
            m_load = rise8 & m_clean[9];
            if (m_load) m_seed = m_clean[7:0];
            fire   = m_auto && (cyc == m_next);
            m_step = !m_load && (m_auto ? fire : (rise8 && !m_clean[9]));
            if (riseb) begin
                m_auto = !m_auto;
                m_next = cyc + AD;
            end else if (m_auto && (m_load || fire)) begin
                m_next = cyc + AD;
            end
            for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = raw;
            m_prev  = m_clean;
            for (int b = 0; b < 11; b++) begin
                same = 1'b1;
                for (int k = 3; k <= DB + 1; k++) if (hist[k][b] !== hist[2][b]) same = 1'b0;
                if (same && hist[2][b] !== m_clean[b]) m_clean[b] = hist[2][b];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        chk("sw_clean", 32'(bus.sw_clean), 32'(m_clean[9:0]));
        chk("seed", 32'(bus.seed), 32'(m_seed));
        chk("step_pulse", 32'(bus.step_pulse), 32'(m_step));
        chk("load_pulse", 32'(bus.load_pulse), 32'(m_load));
        chk("auto_mode", 32'(bus.auto_mode), 32'(m_auto));
        if (bus.step_pulse) begin
            steps++;
            if (first_step < 0) first_step = cyc;
        end
        if (bus.load_pulse) loads++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_auto(input logic v);
        for (int k = 0; k < 40 && bus.auto_mode !== v; k++) tick();
        chk("auto_wait", 32'(bus.auto_mode), 32'(v));
    endtask

    initial begin
        int t0, n, b;
        bus.sw_in    = '0;
        bus.btn_auto = 1'b0;
        rst          = 1'b1;
        ticks(3);
        chk("rst_clean", 32'(bus.sw_clean), 32'h0);
        chk("rst_auto", 32'(bus.auto_mode), 32'h0);
        rst = 1'b0;
        ticks(2);

        // single step: pulse lands 7 cycles after the raw change
        t0 = cyc; steps = 0; first_step = -1;
        bus.sw_in[8] = 1'b1;
        ticks(20);
        chk("step_latency", 32'(first_step - t0), 32'd7);
        chk("step_count", 32'(steps), 32'd1);
        chk("step_clean8", 32'(bus.sw_clean[8]), 32'd1);

        // 3-cycle glitch is filtered out
        bus.sw_in[8] = 1'b0;
        ticks(10);
        steps = 0;
        bus.sw_in[8] = 1'b1;
        ticks(3);
        bus.sw_in[8] = 1'b0;
        ticks(15);
        chk("glitch_steps", 32'(steps), 32'd0);
        chk("glitch_clean8", 32'(bus.sw_clean[8]), 32'd0);

        // seed load
        bus.sw_in[7:0] = 8'hA5;
        bus.sw_in[9]   = 1'b1;
        ticks(10);
        steps = 0; loads = 0;
        bus.sw_in[8] = 1'b1;
        ticks(15);
        chk("load_count", 32'(loads), 32'd1);
        chk("load_steps", 32'(steps), 32'd0);
        chk("load_seed", 32'(bus.seed), 32'hA5);
        bus.sw_in = '0;
        ticks(10);

        // random switch/button activity with occasional resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(5) == 0) begin
                b = ($urandom_range(1) == 1) ? int'($urandom_range(10, 8)) : int'($urandom_range(10));
                if (b == 10) bus.btn_auto = ~bus.btn_auto;
                else         bus.sw_in[b] = ~bus.sw_in[b];
            end
            rst = ($urandom_range(299) == 0);
            tick();
        end
        bus.sw_in = '0; bus.btn_auto = 1'b0; rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(2);

`ifdef SW_STEP_AUTO_STEP_EN
        // auto mode on: 5 steps in 40 cycles, then off: none
        bus.btn_auto = 1'b1;
        wait_auto(1'b1);
        bus.btn_auto = 1'b0;
        steps = 0;
        ticks(40);
        chk("auto_pulses", 32'(steps), 32'd5);
        bus.btn_auto = 1'b1;
        wait_auto(1'b0);
        bus.btn_auto = 1'b0;
        steps = 0;
        ticks(30);
        chk("auto_off_pulses", 32'(steps), 32'd0);

        // load edge timed onto the second prescaler wrap
        bus.btn_auto = 1'b1;
        wait_auto(1'b1);
        n = cyc;
        bus.sw_in[9] = 1'b1;
        ticks(9);
        bus.sw_in[8] = 1'b1;
        ticks(7);
        chk("coinc_load", 32'(bus.load_pulse), 32'd1);
        chk("coinc_step", 32'(bus.step_pulse), 32'd0);
        chk("coinc_cycle", 32'(cyc - n), 32'd16);
        steps = 0; first_step = -1;
        ticks(8);
        chk("coinc_next_gap", 32'(first_step - (n + 16)), 32'd8);
        bus.btn_auto = 1'b0;
`endif

        // reset mid-debounce (and in AUTO when built with it)
        bus.sw_in = 10'h008;
        ticks(3);
        rst = 1'b1;
        ticks(2);
        chk("mid_rst_clean", 32'(bus.sw_clean), 32'h0);
        chk("mid_rst_auto", 32'(bus.auto_mode), 32'h0);
        chk("mid_rst_seed", 32'(bus.seed), 32'h0);
        bus.sw_in = '0;
        rst = 1'b0;
        steps = 0; loads = 0;
        ticks(20);
        chk("post_rst_steps", 32'(steps), 32'd0);
        chk("post_rst_loads", 32'(loads), 32'd0);
        chk("post_rst_auto", 32'(bus.auto_mode), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
